// File: rtl/cmp_sort_ctrl.sv
// Frame sorter: loads N 4-bit words, bubble-sorts them in place through one shared
// comparator (one compare-and-swap per cycle), then drains them in sorted order.
module cmp_sort_ctrl #(
    parameter int unsigned N          = 8,
    parameter bit          DESCENDING = 1'b0,
    localparam int unsigned IW        = $clog2(N),
    localparam int unsigned SCW       = $clog2(N * (N - 1) / 2 + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [3:0]     in_data_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [3:0]     out_data_o,
    output logic           busy_o,
    output logic [SCW-1:0] swap_count_o
);

    localparam logic [IW-1:0]  IdxOne      = IW'(1);
    localparam logic [IW-1:0]  IdxLast     = IW'(N - 1);
    localparam logic [IW-1:0]  IdxLastPair = IW'(N - 2);
    localparam logic [SCW-1:0] CntOne      = SCW'(1);

    typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

    state_e          state_q, state_d;
    logic [3:0]      mem_q [N];
    logic [3:0]      mem_d [N];
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   pass_q, pass_d;
    logic            pass_swapped_q, pass_swapped_d;
    logic [SCW-1:0]  swap_count_q, swap_count_d;

    logic [IW-1:0]   i_next;
    logic [3:0]      left, right;
    logic            gt, lt, eq;
    logic            do_swap;

    // Shared comparator on the adjacent pair selected by i.
    assign i_next  = i_q + IdxOne;
    assign left    = mem_q[i_q];
    assign right   = mem_q[i_next];
    assign gt      = left > right;
    assign lt      = left < right;
    assign eq      = left == right;
    assign do_swap = !eq && (DESCENDING ? lt : gt);

    assign out_data_o   = mem_q[rd_idx_q];
    assign busy_o       = state_q != StLoad;
    assign swap_count_o = swap_count_q;

    always_comb begin
        state_d        = state_q;
        mem_d          = mem_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_q;
        i_d            = i_q;
        pass_d         = pass_q;
        pass_swapped_d = pass_swapped_q;
        swap_count_d   = swap_count_q;
        in_ready_o     = 1'b0;
        out_valid_o    = 1'b0;

        unique case (state_q)
            StLoad: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    mem_d[wr_idx_q] = in_data_i;
                    if (wr_idx_q == IdxLast) begin
                        wr_idx_d       = '0;
                        i_d            = '0;
                        pass_d         = '0;
                        pass_swapped_d = 1'b0;
                        swap_count_d   = '0;
                        state_d        = StSort;
                    end else begin
                        wr_idx_d = wr_idx_q + IdxOne;
                    end
                end
            end
            StSort: begin
                if (do_swap) begin
                    mem_d[i_q]     = right;
                    mem_d[i_next]  = left;
                    swap_count_d   = swap_count_q + CntOne;
                    pass_swapped_d = 1'b1;
                end
                // Pass p stops one slot earlier each time: the tail is already in place.
                if (i_q == IdxLastPair - pass_q) begin
                    if (!(pass_swapped_q || do_swap) || pass_q == IdxLastPair) begin
                        state_d  = StDrain;
                        rd_idx_d = '0;
                    end else begin
                        pass_d         = pass_q + IdxOne;
                        i_d            = '0;
                        pass_swapped_d = 1'b0;
                    end
                end else begin
                    i_d = i_next;
                end
            end
            StDrain: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (rd_idx_q == IdxLast) begin
                        rd_idx_d = '0;
                        state_d  = StLoad;
                    end else begin
                        rd_idx_d = rd_idx_q + IdxOne;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StLoad;
            mem_q          <= '{default: '0};
            wr_idx_q       <= '0;
            rd_idx_q       <= '0;
            i_q            <= '0;
            pass_q         <= '0;
            pass_swapped_q <= 1'b0;
            swap_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            mem_q          <= mem_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            i_q            <= i_d;
            pass_q         <= pass_d;
            pass_swapped_q <= pass_swapped_d;
            swap_count_q   <= swap_count_d;
        end
    end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Bench for cmp_sort_ctrl: one ascending and one descending instance, directed and random
// frames checked against a histogram/inversion-count reference model.
module tb_cmp_sort_ctrl;

    localparam int unsigned N   = 8;
    localparam int unsigned SCW = 5;

    typedef logic [3:0] frame_t [N];

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     in_valid;
    logic [3:0]     in_data;
    logic [1:0]     out_ready;
    logic [1:0]     in_ready, out_valid, busy;
    logic [3:0]     out_data_a, out_data_d;
    logic [SCW-1:0] swap_a, swap_d;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cmp_sort_ctrl #(.N(N), .DESCENDING(1'b0)) dut_asc (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data_a),
        .busy_o(busy[0]), .swap_count_o(swap_a)
    );

    cmp_sort_ctrl #(.N(N), .DESCENDING(1'b1)) dut_dsc (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data_d),
        .busy_o(busy[1]), .swap_count_o(swap_d)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] odata(input bit d);
        return d ? out_data_d : out_data_a;
    endfunction

    function automatic logic [SCW-1:0] oswap(input bit d);
        return d ? swap_d : swap_a;
    endfunction

    // "Out of order" relation for the chosen direction.
    function automatic bit inverted(input bit d, input logic [3:0] a, input logic [3:0] b);
        return d ? (a < b) : (a > b);
    endfunction

    // Bubble-sort swaps equal the number of inverted pairs.
    function automatic int model_swaps(input bit d, input frame_t w);
        int s = 0;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < j; i++)
                if (inverted(d, w[i], w[j])) s++;
        return s;
    endfunction

    // Each pass moves a word left by at most one slot; one extra clean pass confirms order.
    function automatic int model_sort_cycles(input bit d, input frame_t w);
        int m = 0;
        int p;
        int k = 0;
        for (int j = 0; j < N; j++) begin
            int c = 0;
            for (int i = 0; i < j; i++)
                if (inverted(d, w[i], w[j])) c++;
            if (c > m) m = c;
        end
        p = (m + 1 > N - 1) ? N - 1 : m + 1;
        for (int q = 0; q < p; q++) k += N - 1 - q;
        return k;
    endfunction

    function automatic frame_t model_sorted(input bit d, input frame_t w);
        frame_t r;
        int hist [16];
        int n = 0;
        for (int v = 0; v < 16; v++) hist[v] = 0;
        foreach (w[i]) hist[w[i]]++;
        for (int s = 0; s < 16; s++) begin
            int v = d ? 15 - s : s;
            for (int c = 0; c < hist[v]; c++) begin
                r[n] = 4'(v);
                n++;
            end
        end
        return r;
    endfunction

    task automatic load_frame(input bit d, input frame_t w);
        int idx = 0;
        int cyc = 0;
        bit hs;
        while (idx < N && cyc < 200) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid[d] = 1'b0;
                in_data     = 4'($urandom);
            end else begin
                in_valid[d] = 1'b1;
                in_data     = w[idx];
            end
            check_eq("in_ready_load", in_ready[d], 1'b1);
            check_eq("out_valid_load", out_valid[d], 1'b0);
            hs = in_valid[d] && in_ready[d];
            @(posedge clk);
            #1;
            if (hs) idx++;
            cyc++;
        end
        check_eq("load_complete", idx, N);
        // Junk on the input and a ready output while busy must be ignored.
        in_valid[d]  = 1'b1;
        in_data      = 4'($urandom);
        out_ready[d] = 1'b1;
    endtask

    task automatic sort_drain(input bit d, input frame_t w, input int rmode);
        frame_t exp_w = model_sorted(d, w);
        int     k_exp = model_sort_cycles(d, w);
        int     s_exp = model_swaps(d, w);
        int     c = 0;
        int     got = 0;
        int     cyc = 0;
        bit     prev_stall = 1'b0;
        logic [3:0] prev_data = '0;
        bit     r;

        check_eq("busy_sort", busy[d], 1'b1);
        check_eq("swap_cleared", oswap(d), 0);
        while (!out_valid[d] && c < 200) begin
            check_eq("in_ready_sort", in_ready[d], 1'b0);
            @(posedge clk);
            #1;
            c++;
        end
        check_eq("sort_cycles", c, k_exp);
        while (got < N && cyc < 400) begin
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 3) == 0;
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready[d] = r;
            in_data      = 4'($urandom);
            check_eq("out_valid_drain", out_valid[d], 1'b1);
            check_eq("in_ready_drain", in_ready[d], 1'b0);
            check_eq("busy_drain", busy[d], 1'b1);
            if (prev_stall) check_eq("stall_stable", odata(d), prev_data);
            if (r) check_eq($sformatf("out_word%0d", got), odata(d), exp_w[got]);
            prev_stall = !r;
            prev_data  = odata(d);
            @(posedge clk);
            #1;
            if (r) got++;
            cyc++;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        check_eq("drain_complete", got, N);
        if (rmode == 0) check_eq("drain_cycles", cyc, N);
        check_eq("in_ready_after", in_ready[d], 1'b1);
        check_eq("out_valid_after", out_valid[d], 1'b0);
        check_eq("busy_after", busy[d], 1'b0);
        check_eq("swap_count", oswap(d), s_exp);
    endtask

    task automatic run_frame(input bit d, input frame_t w, input int rmode);
        load_frame(d, w);
        sort_drain(d, w, rmode);
    endtask

    task automatic check_idle(input bit d);
        check_eq("rst_in_ready", in_ready[d], 1'b1);
        check_eq("rst_out_valid", out_valid[d], 1'b0);
        check_eq("rst_busy", busy[d], 1'b0);
        check_eq("rst_swap", oswap(d), 0);
        check_eq("rst_out_data", odata(d), 0);
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        bit narrow = 1'($urandom_range(0, 1));
        foreach (f[i]) f[i] = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom);
        return f;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        frame_t f;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle(1'b0);
        check_idle(1'b1);
        rst_n = 1'b1;

        // Reset in the third SORT cycle discards the frame.
        f = '{4'h7, 4'h3, 4'hE, 4'h1, 4'h9, 4'h0, 4'hC, 4'h5};
        load_frame(1'b0, f);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle(1'b0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b0;
        check_idle(1'b0);
        run_frame(1'b0, f, 0);

        f = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        run_frame(1'b0, f, 0);
        f = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
        run_frame(1'b0, f, 0);
        f = '{4'hA, 4'h0, 4'hB, 4'hE, 4'hF, 4'hF, 4'h3, 4'h9};
        run_frame(1'b0, f, 0);
        f = '{4'h4, 4'hB, 4'h2, 4'h2, 4'hD, 4'h0, 4'h8, 4'h6};
        run_frame(1'b0, f, 1);
        f = '{4'h1, 4'h5, 4'h5, 4'h0, 4'hC, 4'h8, 4'h7, 4'h2};
        run_frame(1'b1, f, 0);
        f = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        run_frame(1'b1, f, 1);

        for (int n = 0; n < 24; n++) begin
            f = rand_frame();
            run_frame(1'(n % 2), f, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
